ariscv_fetch: RTL

// - Fetch stage: drives the {instruction, PC, PC+4} interface that the decode stage consumes.
// - Generates sequential PCs, issues req/gnt/rvalid reads to instruction memory and queues responses in a small buffer.
// - Presents buffered instructions to decode under a valid/ready handshake.
// - Takes a PC redirect (branch/jump target) from execute and flushes all younger fetched work.

---
 rtl/ariscv_pkg.sv | 13 +
 rtl/ariscv_fetch_buf.sv | 63 ++++++
 rtl/ariscv_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/ariscv_pkg.sv
// Shared fetch-stage types: NOP encoding, FSM states and the buffered fetch entry.
package ariscv_pkg;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ariscv_fetch_buf.sv
// Small synchronous FIFO of fetched {pc, inst} entries with single-cycle flush.
module ariscv_fetch_buf
  import ariscv_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             fe_aclk,
  input  logic             rst_async,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge fe_aclk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; empty masks it at the outputs.
  always_ff @(posedge fe_aclk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  a_no_pop_empty: assert property (@(posedge fe_aclk) disable iff (rst_async) !(pop && empty));
  a_no_push_full: assert property (@(posedge fe_aclk) disable iff (rst_async) !(push && full));

endmodule

// File: rtl/ariscv_fetch.sv
// Fetch stage: sequential PC generation, single-outstanding imem reads, buffered
// delivery to decode, and redirect with flush of younger work.
module ariscv_fetch
  import ariscv_pkg::*;
#(
  parameter int                NBW_INST  = 32,
  parameter int                NBW_PC    = 32,
  parameter logic [NBW_PC-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic                fe_aclk,
  input  logic                rst_async,
  output logic                o_imem_req,
  output logic [NBW_PC-1:0]   o_imem_addr,
  input  logic                i_imem_gnt,
  input  logic                i_imem_rvalid,
  input  logic [NBW_INST-1:0] i_imem_rdata,
  input  logic                i_redirect,
  input  logic [NBW_PC-1:0]   i_redirect_pc,
  output logic                o_valid_fd,
  input  logic                i_ready_fd,
  output logic [NBW_INST-1:0] o_inst,
  output logic [NBW_PC-1:0]   o_pc_fd,
  output logic [NBW_PC-1:0]   o_pc_plus4_fd
);

  localparam int                CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [NBW_PC-1:0] PC_STEP = NBW_PC'(4);
  localparam logic [NBW_PC-1:0] PC_RST  = {RESET_PC[NBW_PC-1:2], 2'b00};

  typedef struct packed {
    logic [NBW_PC-1:0]   pc;
    logic [NBW_INST-1:0] inst;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [NBW_PC-1:0] pc_q, pc_d, redir_pc;
  entry_t            push_data, head;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty, buf_full;
  logic              push, pop, credit_after_push;

  assign redir_pc  = {i_redirect_pc[NBW_PC-1:2], 2'b00};
  assign pop       = o_valid_fd & i_ready_fd;
  // pc_q already advanced at gnt, so the in-flight request address is pc_q - 4.
  assign push      = (state_q == WAIT) & i_imem_rvalid & ~i_redirect;
  assign push_data = '{pc: pc_q - PC_STEP, inst: i_imem_rdata};
  assign credit_after_push = (int'(buf_count) + 1 - int'(pop)) < BUF_DEPTH;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE:    if (!buf_full) state_d = REQ;
      REQ:     if (i_imem_gnt) begin
                 state_d = WAIT;
                 pc_d    = pc_q + PC_STEP;
               end
      WAIT:    if (i_imem_rvalid) state_d = credit_after_push ? REQ : IDLE;
      DRAIN:   if (i_imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (i_redirect) begin
      pc_d = redir_pc;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = i_imem_gnt ? DRAIN : IDLE;
        WAIT:    state_d = i_imem_rvalid ? REQ : DRAIN;
        // A response arriving in the redirect cycle is the one being drained.
        DRAIN:   state_d = i_imem_rvalid ? REQ : DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge fe_aclk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ariscv_fetch_buf #(
    .DEPTH   (BUF_DEPTH),
    .entry_t (entry_t)
  ) u_buf (
    .fe_aclk   (fe_aclk),
    .rst_async (rst_async),
    .flush     (i_redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign o_imem_req    = (state_q == REQ);
  assign o_imem_addr   = pc_q;
  assign o_valid_fd    = ~buf_empty;
  assign o_inst        = buf_empty ? NBW_INST'(FETCH_NOP) : head.inst;
  assign o_pc_fd       = buf_empty ? '0 : head.pc;
  assign o_pc_plus4_fd = buf_empty ? '0 : head.pc + PC_STEP;

endmodule
